// File: rtl/agg_buffer_reader.sv
// agg_buffer_reader: turns a (base, len) command into one buffer line read per cycle
// and streams the returned lines out in order through a credit-protected return FIFO.
module agg_buffer_reader #(
  parameter int BUFFER_ADDR_WIDTH = 11,
  parameter int BUFFER_DATA_WIDTH = 512,
  parameter int LEN_WIDTH         = 12,
  parameter int READ_LATENCY      = 4,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [BUFFER_ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [LEN_WIDTH-1:0]         cmd_len,
  output logic                         cmd_done,
  output logic                         agg_read_addr_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] agg_read_addr,
  input  logic                         agg_read_data_valid,
  input  logic [BUFFER_DATA_WIDTH-1:0] agg_read_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BUFFER_DATA_WIDTH-1:0] out_data,
  output logic                         out_last
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CRED_W = PTR_W + 1;
  localparam logic [CRED_W-1:0]    DEPTH_C  = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0]    CRED_ONE = CRED_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  if (FIFO_DEPTH < READ_LATENCY + 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("agg_buffer_reader: FIFO_DEPTH must be a power of two >= READ_LATENCY+2");
  end

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_next;

  logic [BUFFER_ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]         len_q;
  logic [LEN_WIDTH-1:0]         len_m1;
  logic [LEN_WIDTH-1:0]         issue_cnt;
  logic [LEN_WIDTH-1:0]         pop_cnt;
  logic [CRED_W-1:0]            outstanding;
  logic [CRED_W-1:0]            wr_ptr;
  logic [CRED_W-1:0]            rd_ptr;
  logic [BUFFER_DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic                         cmd_accept;
  logic                         fire;
  logic                         pop;
  logic                         credit_ok;
  logic [BUFFER_ADDR_WIDTH-1:0] issue_addr;

  assign len_m1    = len_q - LEN_ONE;
  assign out_valid = (wr_ptr != rd_ptr);
  assign pop       = out_valid & out_ready;
  // Outstanding counts lines issued but not yet popped, so it bounds in-flight plus
  // stored; a pop in the same cycle frees its slot in time for this issue.
  assign credit_ok = (outstanding < DEPTH_C) | pop;

  assign cmd_ready = (state == IDLE);
  assign cmd_done  = (state == DONE);
  assign out_data  = out_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
  assign out_last  = out_valid & (pop_cnt == len_m1);

  // The read port is registered, so line 0 is launched in the accept cycle itself
  // to appear on the bus the cycle after the command handshake.
  always_comb begin
    state_next = state;
    cmd_accept = 1'b0;
    fire       = 1'b0;
    issue_addr = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          cmd_accept = 1'b1;
          if (cmd_len == '0) begin
            state_next = DONE;
          end else begin
            fire       = 1'b1;
            issue_addr = cmd_base_addr;
            state_next = (cmd_len == LEN_ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        issue_addr = base_q + BUFFER_ADDR_WIDTH'(issue_cnt);
        if (credit_ok) begin
          fire = 1'b1;
          if (issue_cnt == len_m1) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (pop_cnt == len_m1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
    end else begin
      if (cmd_accept) begin
        base_q    <= cmd_base_addr;
        len_q     <= cmd_len;
        issue_cnt <= (cmd_len == '0) ? '0 : LEN_ONE;
        pop_cnt   <= '0;
      end else begin
        if (fire) begin
          issue_cnt <= issue_cnt + LEN_ONE;
        end
        if (pop) begin
          pop_cnt <= pop_cnt + LEN_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding         <= '0;
      agg_read_addr_valid <= 1'b0;
      agg_read_addr       <= '0;
    end else begin
      case ({fire, pop})
        2'b10:   outstanding <= outstanding + CRED_ONE;
        2'b01:   outstanding <= outstanding - CRED_ONE;
        default: outstanding <= outstanding;
      endcase
      agg_read_addr_valid <= fire;
      agg_read_addr       <= fire ? issue_addr : '0;
    end
  end

  // Return FIFO pointers carry one extra wrap bit so full and empty are distinct.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (agg_read_data_valid) begin
        wr_ptr <= wr_ptr + CRED_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + CRED_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (agg_read_data_valid) begin
      mem[wr_ptr[PTR_W-1:0]] <= agg_read_data;
    end
  end

endmodule

// File: tb/tb_agg_buffer_reader.sv
// tb_agg_buffer_reader: drives commands into agg_buffer_reader against a 4-cycle buffer model
// and checks the read addresses and output stream against per-command expected lines.
module tb_agg_buffer_reader;

  localparam int AW    = 11;
  localparam int DW    = 512;
  localparam int LW    = 12;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_done;
  logic          agg_read_addr_valid;
  logic [AW-1:0] agg_read_addr;
  logic          agg_read_data_valid;
  logic [DW-1:0] agg_read_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  agg_buffer_reader #(
    .BUFFER_ADDR_WIDTH(AW),
    .BUFFER_DATA_WIDTH(DW),
    .LEN_WIDTH(LW),
    .READ_LATENCY(4),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr),
    .cmd_len(cmd_len),
    .cmd_done(cmd_done),
    .agg_read_addr_valid(agg_read_addr_valid),
    .agg_read_addr(agg_read_addr),
    .agg_read_data_valid(agg_read_data_valid),
    .agg_read_data(agg_read_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic [DW-1:0] line_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) begin
      d[i*32 +: 32] = {a, i[4:0], 16'({5'b0, a} * 16'd977 + 16'(i))};
    end
    return d;
  endfunction

  // Buffer model: fixed four-cycle read latency, flushed by reset like the real buffer.
  logic [3:0]    vpipe;
  logic [AW-1:0] apipe [4];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int i = 0; i < 4; i++) apipe[i] <= '0;
    end else begin
      vpipe    <= {vpipe[2:0], agg_read_addr_valid};
      apipe[0] <= agg_read_addr;
      apipe[1] <= apipe[0];
      apipe[2] <= apipe[1];
      apipe[3] <= apipe[2];
    end
  end
  assign agg_read_data_valid = vpipe[3];
  assign agg_read_data       = vpipe[3] ? line_data(apipe[3]) : '0;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int issued = 0, returned = 0, popped = 0;
  int total_issues = 0, total_beats = 0, total_lasts = 0, total_dones = 0, last_beat_cycle = 0;

  // Reference model: each accepted command expands into its list of line addresses and
  // expected beats; every read, return, beat and done is checked against those lists.
  initial begin
    bit            hold;
    logic [DW-1:0] hold_data;
    logic          hold_last;
    logic [AW-1:0] a;
    beat_t         b;
    hold = 1'b0;
    hold_data = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_addr_q.delete();
        issued = 0;
        returned = 0;
        popped = 0;
        hold = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          for (int i = 0; i < int'(cmd_len); i++) begin
            a = cmd_base_addr + AW'(i);
            b.data = line_data(a);
            b.last = (i == int'(cmd_len) - 1);
            exp_addr_q.push_back(a);
            exp_q.push_back(b);
          end
        end
        if (agg_read_data_valid) begin
          checkOutput("return_inflight", DW'(returned < issued), DW'(1));
          checkOutput("fifo_no_overflow", DW'((returned - popped) < DEPTH), DW'(1));
          returned++;
        end
        if (agg_read_addr_valid) begin
          total_issues++;
          issued++;
          checkOutput("read_expected", DW'(exp_addr_q.size() > 0), DW'(1));
          if (exp_addr_q.size() > 0) begin
            a = exp_addr_q.pop_front();
            checkOutput("read_addr", DW'(agg_read_addr), DW'(a));
          end
          checkOutput("issue_credit", DW'((issued - popped) <= DEPTH), DW'(1));
        end
        if (hold) begin
          checkOutput("hold_valid", DW'(out_valid), DW'(1));
          checkOutput("hold_data", out_data, hold_data);
          checkOutput("hold_last", DW'(out_last), DW'(hold_last));
        end
        if (out_valid && out_ready) begin
          checkOutput("beat_expected", DW'(exp_q.size() > 0), DW'(1));
          if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            checkOutput("out_data", out_data, b.data);
            checkOutput("out_last", DW'(out_last), DW'(b.last));
          end
          total_beats++;
          if (out_last) total_lasts++;
          last_beat_cycle = cycle;
          popped++;
        end
        hold = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
        if (cmd_done) begin
          total_dones++;
          checkOutput("done_all_beats", DW'(exp_q.size()), DW'(0));
        end
      end
    end
  end

  // Offers a command from a posedge+1 alignment; t is the handshake cycle.
  task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len,
                               input bit keep_valid, output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    cmd_base_addr = base;
    cmd_len = len;
    cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        t = cycle;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("cmd_accept", DW'(ok), DW'(1));
    @(posedge clk);
    #1;
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag, input bit rnd, input int budget, output int td);
    bit found;
    found = 1'b0;
    td = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cmd_done) begin
        td = cycle;
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    checkOutput({tag, "_done_seen"}, DW'(found), DW'(1));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_cmd_ready"}, DW'(cmd_ready), DW'(1));
    checkOutput({tag, "_cmd_done"}, DW'(cmd_done), DW'(0));
    checkOutput({tag, "_rd_valid"}, DW'(agg_read_addr_valid), DW'(0));
    checkOutput({tag, "_rd_addr"}, DW'(agg_read_addr), DW'(0));
    checkOutput({tag, "_out_valid"}, DW'(out_valid), DW'(0));
    checkOutput({tag, "_out_data"}, out_data, DW'(0));
    checkOutput({tag, "_out_last"}, DW'(out_last), DW'(0));
  endtask

  initial begin
    int t, t2, td, td2, b0, l0, i0, d0;
    logic [AW-1:0] wrap_exp [4];
    logic [AW-1:0] rbase;
    logic [LW-1:0] rlen;

    wrap_exp = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkIdle("reset");
    @(posedge clk);
    #1;

    $display("[TB] basic read");
    b0 = total_beats;
    l0 = total_lasts;
    applyStimulus(11'h010, 12'd4, 1'b0, t);
    @(negedge clk);
    checkOutput("basic_first_valid", DW'(agg_read_addr_valid), DW'(1));
    checkOutput("basic_first_addr", DW'(agg_read_addr), DW'(11'h010));
    waitDone("basic", 1'b0, 100, td);
    checkOutput("basic_done_cycle", DW'(td - t), DW'(10));
    checkOutput("basic_last_beat_cycle", DW'(last_beat_cycle - t), DW'(9));
    checkOutput("basic_beats", DW'(total_beats - b0), DW'(4));
    checkOutput("basic_lasts", DW'(total_lasts - l0), DW'(1));
    checkOutput("basic_busy_at_done", DW'(cmd_ready), DW'(0));
    @(negedge clk);
    checkOutput("basic_ready_after", DW'(cmd_ready), DW'(1));
    @(posedge clk);
    #1;

    $display("[TB] address wrap");
    b0 = total_beats;
    applyStimulus(11'h7FE, 12'd4, 1'b0, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wrap_valid", DW'(agg_read_addr_valid), DW'(1));
      checkOutput("wrap_addr", DW'(agg_read_addr), DW'(wrap_exp[i]));
    end
    waitDone("wrap", 1'b0, 100, td);
    checkOutput("wrap_beats", DW'(total_beats - b0), DW'(4));
    @(posedge clk);
    #1;

    $display("[TB] backpressure");
    out_ready = 1'b0;
    i0 = total_issues;
    b0 = total_beats;
    l0 = total_lasts;
    applyStimulus(11'h200, 12'd16, 1'b0, t);
    repeat (28) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_issue_stall_count", DW'(total_issues - i0), DW'(8));
    checkOutput("bp_issue_idle", DW'(agg_read_addr_valid), DW'(0));
    checkOutput("bp_out_valid", DW'(out_valid), DW'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    waitDone("bp", 1'b0, 200, td);
    checkOutput("bp_beats", DW'(total_beats - b0), DW'(16));
    checkOutput("bp_lasts", DW'(total_lasts - l0), DW'(1));
    checkOutput("bp_issues", DW'(total_issues - i0), DW'(16));
    @(posedge clk);
    #1;

    $display("[TB] zero length");
    i0 = total_issues;
    b0 = total_beats;
    applyStimulus(11'h055, 12'd0, 1'b0, t);
    @(negedge clk);
    checkOutput("zero_done_cycle", DW'(cmd_done), DW'(1));
    checkOutput("zero_no_read", DW'(agg_read_addr_valid), DW'(0));
    @(negedge clk);
    checkOutput("zero_ready_again", DW'(cmd_ready), DW'(1));
    checkOutput("zero_done_pulse", DW'(cmd_done), DW'(0));
    checkOutput("zero_out_idle", DW'(out_valid), DW'(0));
    checkOutput("zero_issues", DW'(total_issues - i0), DW'(0));
    checkOutput("zero_beats", DW'(total_beats - b0), DW'(0));
    @(posedge clk);
    #1;

    $display("[TB] reset mid-command");
    i0 = total_issues;
    d0 = total_dones;
    applyStimulus(11'h300, 12'd8, 1'b0, t);
    for (int k = 0; k < 20 && (total_issues - i0) < 3; k++) @(negedge clk);
    checkOutput("rst_three_issued", DW'((total_issues - i0) >= 3), DW'(1));
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkIdle("rst_held");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkIdle("rst_release");
    repeat (10) @(negedge clk);
    checkOutput("rst_no_done", DW'(total_dones - d0), DW'(0));
    @(posedge clk);
    #1;
    b0 = total_beats;
    applyStimulus(11'h020, 12'd2, 1'b0, t);
    waitDone("rst_next", 1'b0, 100, td);
    checkOutput("rst_next_done_cycle", DW'(td - t), DW'(8));
    checkOutput("rst_next_beats", DW'(total_beats - b0), DW'(2));
    @(posedge clk);
    #1;

    $display("[TB] back-to-back");
    b0 = total_beats;
    l0 = total_lasts;
    applyStimulus(11'h000, 12'd3, 1'b1, t);
    cmd_base_addr = 11'h100;
    cmd_len = 12'd2;
    waitDone("b2b_first", 1'b0, 100, td);
    applyStimulus(11'h100, 12'd2, 1'b0, t2);
    checkOutput("b2b_second_accept", DW'(t2 - td), DW'(1));
    waitDone("b2b_second", 1'b0, 100, td2);
    checkOutput("b2b_beats", DW'(total_beats - b0), DW'(5));
    checkOutput("b2b_lasts", DW'(total_lasts - l0), DW'(2));
    @(posedge clk);
    #1;

    $display("[TB] randomized commands");
    for (int n = 0; n < 12; n++) begin
      rbase = AW'($urandom_range(0, 2047));
      rlen = (n % 4 == 3) ? 12'd0 : LW'($urandom_range(1, 40));
      applyStimulus(rbase, rlen, 1'b0, t);
      waitDone("rand", 1'b1, 3000, td);
      if (rlen == 12'd0) begin
        checkOutput("rand_zero_latency", DW'(td - t), DW'(1));
      end else begin
        checkOutput("rand_min_latency", DW'((td - t) >= int'(rlen) + 6), DW'(1));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    repeat (3) @(negedge clk);
    checkOutput("final_expected_empty", DW'(exp_q.size()), DW'(0));
    checkOutput("final_reads_empty", DW'(exp_addr_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
